// File: rtl/pdm_pkg.sv
// Shared types, full-scale constant and saturation helper for the PDM playback path.
package pdm_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ACC_WIDTH  = 24;

    typedef logic signed [DATA_WIDTH-1:0] pcm_sample_t;
    typedef logic signed [ACC_WIDTH-1:0]  pdm_acc_t;
    typedef logic signed [ACC_WIDTH+1:0]  pdm_wide_t;

    localparam pdm_acc_t PDM_FS = pdm_acc_t'(2 ** (DATA_WIDTH - 1));

    // Two guard bits are enough for acc + sample - feedback; clamp back to ACC_WIDTH.
    function automatic pdm_acc_t saturate(input pdm_wide_t value);
        logic [2:0] top;
        top = value[ACC_WIDTH+1:ACC_WIDTH-1];
        if (top == 3'b000 || top == 3'b111) begin
            return pdm_acc_t'(value[ACC_WIDTH-1:0]);
        end else if (value[ACC_WIDTH+1]) begin
            return pdm_acc_t'({1'b1, {(ACC_WIDTH-1){1'b0}}});
        end else begin
            return pdm_acc_t'({1'b0, {(ACC_WIDTH-1){1'b1}}});
        end
    endfunction

endpackage

// File: rtl/pdm_sigma_delta.sv
// Second-order sigma-delta modulator: one step per strobe, registered 1-bit output.
module pdm_sigma_delta
    import pdm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  pdm_bit
);

    pdm_acc_t  i1;
    pdm_acc_t  i2;
    pdm_acc_t  i1_next;
    pdm_acc_t  i2_next;
    pdm_wide_t fb;

    // Feedback is the previously emitted bit mapped to +/- full scale.
    always_comb begin
        fb      = pdm_bit ? pdm_wide_t'(PDM_FS) : -pdm_wide_t'(PDM_FS);
        i1_next = saturate(pdm_wide_t'(i1) + pdm_wide_t'($signed(x)) - fb);
        i2_next = saturate(pdm_wide_t'(i2) + pdm_wide_t'(i1_next) - fb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1      <= '0;
            i2      <= '0;
            pdm_bit <= 1'b0;
        end else if (clear) begin
            i1      <= '0;
            i2      <= '0;
            pdm_bit <= 1'b0;
        end else if (step) begin
            i1      <= i1_next;
            i2      <= i2_next;
            pdm_bit <= ~i2_next[ACC_WIDTH-1];
        end
    end

endmodule

// File: rtl/pdm_playback.sv
// PCM-to-PDM playback: clock divider, frame counter, one-entry holding register,
// underrun tracking and the sigma-delta modulator driving an external PDM amplifier.
module pdm_playback
    import pdm_pkg::*;
#(
    parameter int CLK_DIV           = 50,
    parameter int OVERSAMPLE_FACTOR = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pcm_in,
    input  logic                  pcm_valid,
    output logic                  pcm_ready,
    output logic                  pdm_clk,
    output logic                  pdm_data,
    output logic                  underrun,
    output logic [15:0]           underrun_count,
    output logic                  active
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = (OVERSAMPLE_FACTOR > 1) ? $clog2(OVERSAMPLE_FACTOR) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF);
    localparam logic [DIV_W-1:0] TICK_AT  = DIV_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OVERSAMPLE_FACTOR - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_tick;
    logic                  frame_tick;
    logic                  accept;
    logic                  full;
    logic                  first_frame;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] current;

    assign bit_tick   = active && (div_cnt == TICK_AT);
    assign frame_tick = bit_tick && (bit_cnt == BIT_LAST);
    assign accept     = pcm_valid && pcm_ready;
    assign div_next   = (!active || div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

    // The first active cycle parks the divider at 0 so every enable starts a fresh PDM period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (!enable) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            active  <= 1'b1;
            div_cnt <= div_next;
            pdm_clk <= (div_next < DIV_HALF);
            if (bit_tick) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
            end
        end
    end

    // pcm_ready is low only while full, so an accept never coincides with a full register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full           <= 1'b0;
            pcm_ready      <= 1'b1;
            hold           <= '0;
            current        <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            first_frame    <= 1'b1;
        end else if (!enable) begin
            full        <= 1'b0;
            pcm_ready   <= 1'b1;
            current     <= '0;
            underrun    <= 1'b0;
            first_frame <= 1'b1;
        end else begin
            underrun <= 1'b0;
            if (frame_tick) begin
                first_frame <= 1'b0;
                if (full) begin
                    current   <= hold;
                    full      <= 1'b0;
                    pcm_ready <= 1'b1;
                end else if (accept) begin
                    current <= pcm_in;
                end else begin
                    current <= '0;
                    if (!first_frame) begin
                        underrun <= 1'b1;
                        if (underrun_count != 16'hFFFF) begin
                            underrun_count <= underrun_count + 16'd1;
                        end
                    end
                end
            end else if (accept) begin
                hold      <= pcm_in;
                full      <= 1'b1;
                pcm_ready <= 1'b0;
            end
        end
    end

    pdm_sigma_delta u_modulator (
        .clk     (clk),
        .rst     (rst),
        .step    (bit_tick),
        .clear   (!enable),
        .x       (current),
        .pdm_bit (pdm_data)
    );

endmodule

// File: tb/tb_pdm_playback.sv
// Directed self-checking bench for pdm_playback: bit patterns, densities, underruns,
// handshake pacing, enable drop and asynchronous reset.
module tb_pdm_playback;

    localparam int CLK_DIV    = 10;
    localparam int OSF        = 64;
    localparam int HALF       = CLK_DIV / 2;
    localparam int FRAME_CLKS = CLK_DIV * OSF;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pcm_in;
    logic        pcm_valid;
    logic        pcm_ready;
    logic        pdm_clk;
    logic        pdm_data;
    logic        underrun;
    logic [15:0] underrun_count;
    logic        active;

    int tests_run    = 0;
    int tests_failed = 0;

    int   cyc           = 0;
    int   bit_idx       = 0;
    int   last_rise     = -1;
    int   period        = 0;
    int   underrun_seen = 0;
    logic pdm_clk_prev  = 1'b0;
    logic        bit_log[$];
    int          accept_cyc[$];
    logic [15:0] accept_val[$];

    always #5 clk = ~clk;

    pdm_playback #(
        .CLK_DIV           (CLK_DIV),
        .OVERSAMPLE_FACTOR (OSF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pcm_in         (pcm_in),
        .pcm_valid      (pcm_valid),
        .pcm_ready      (pcm_ready),
        .pdm_clk        (pdm_clk),
        .pdm_data       (pdm_data),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .active         (active)
    );

    // Observe on the falling edge: PDM bits at pdm_clk rises, underrun pulses and handshakes.
    always @(negedge clk) begin
        cyc++;
        if (pdm_clk && !pdm_clk_prev) begin
            bit_log.push_back(pdm_data);
            bit_idx++;
            if (last_rise >= 0) period = cyc - last_rise;
            last_rise = cyc;
        end
        pdm_clk_prev = pdm_clk;
        if (underrun) underrun_seen++;
        if (pcm_valid && pcm_ready && enable && !rst) begin
            accept_cyc.push_back(cyc);
            accept_val.push_back(pcm_in);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [15:0] data);
        enable    = en;
        pcm_valid = valid;
        pcm_in    = data;
    endtask

    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitBits(input int target, input string tag);
        int limit;
        limit = (target - bit_idx + 2) * CLK_DIV + 10;
        while (bit_idx < target && limit > 0) begin
            advance(1);
            limit--;
        end
        if (bit_idx < target) checkOutput({tag, "_timeout"}, bit_idx, target);
    endtask

    // Hand-derived zero-input stream from cleared integrators; index 0 is the rise before the first tick.
    function automatic logic zeroBit(input int k);
        if (k == 0) return 1'b0;
        if (k <= 2) return 1'b1;
        if (k == 3) return 1'b0;
        return (k % 4 == 0) || (k % 4 == 3);
    endfunction

    task automatic checkPattern(input int from, input int n, input string tag);
        int bad;
        int first_bad;
        bad       = 0;
        first_bad = -1;
        for (int k = 0; k < n; k++) begin
            if (from + k >= bit_log.size() || bit_log[from + k] !== zeroBit(k)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        checkOutput($sformatf("%s(first_bad_bit=%0d)", tag, first_bad), bad, 0);
    endtask

    function automatic int onesIn(input int from, input int n);
        int sum;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            if (from + k < bit_log.size() && bit_log[from + k] === 1'b1) sum++;
        end
        return sum;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          base;
        int          start;
        int          ones;
        int          ur0;
        int          na;
        logic        acc;
        logic [15:0] val;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        advance(3);
        checkOutput("reset_pdm_clk", pdm_clk, 0);
        checkOutput("reset_pdm_data", pdm_data, 0);
        checkOutput("reset_pcm_ready", pcm_ready, 1);
        checkOutput("reset_underrun", underrun, 0);
        checkOutput("reset_underrun_count", underrun_count, 0);
        checkOutput("reset_active", active, 0);
        #2 rst = 1'b0;
        advance(2);

        // Zero input: exact early pattern, density, PDM clock period, no underruns
        base = bit_idx;
        ur0  = underrun_seen;
        applyStimulus(1'b1, 1'b1, 16'h0000);
        advance(1);
        checkOutput("enable_active", active, 1);
        waitBits(base + 41, "zero_start");
        checkPattern(base, 41, "zero_pattern");
        waitBits(base + 1025, "zero_run");
        ones = onesIn(base + 1, 1024);
        checkOutput($sformatf("zero_density(ones=%0d)", ones), (ones >= 508 && ones <= 516), 1);
        checkOutput("pdm_clk_period", period, CLK_DIV);
        checkOutput("zero_underruns", underrun_seen - ur0, 0);

        // Half-scale DC, positive then negative
        applyStimulus(1'b1, 1'b1, 16'h4000);
        start = bit_idx + 3 * OSF;
        waitBits(start + 1024, "half_pos");
        ones = onesIn(start, 1024);
        checkOutput($sformatf("half_pos_density(ones=%0d)", ones), (ones >= 762 && ones <= 774), 1);
        applyStimulus(1'b1, 1'b1, 16'hC000);
        start = bit_idx + 3 * OSF;
        waitBits(start + 1024, "half_neg");
        ones = onesIn(start, 1024);
        checkOutput($sformatf("half_neg_density(ones=%0d)", ones), (ones >= 250 && ones <= 262), 1);
        checkOutput("half_underruns", underrun_seen - ur0, 0);

        // Starvation: first frame exempt, one sample covers frame 2, then one pulse per frame
        applyStimulus(1'b0, 1'b0, 16'h0000);
        advance(2);
        base = bit_idx;
        ur0  = underrun_seen;
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitBits(base + OSF + 1, "starve_f1");
        checkOutput("first_frame_pulses", underrun_seen - ur0, 0);
        checkOutput("first_frame_count", underrun_count, 0);
        applyStimulus(1'b1, 1'b1, 16'h1234);
        advance(1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        waitBits(base + 2 * OSF + 1, "starve_f2");
        checkOutput("loaded_frame_pulses", underrun_seen - ur0, 0);
        for (int k = 1; k <= 3; k++) begin
            waitBits(base + (2 + k) * OSF + 1, "starve_fk");
            checkOutput($sformatf("starve_count_%0d", k), underrun_count, k);
            checkOutput($sformatf("starve_pulses_%0d", k), underrun_seen - ur0, k);
        end

        // Saturation from a preset of 0xFFFE
        force dut.underrun_count = 16'hFFFE;
        #1 release dut.underrun_count;
        checkOutput("preset_count", underrun_count, 16'hFFFE);
        waitBits(base + 6 * OSF + 1, "sat_f6");
        checkOutput("sat_count_first", underrun_count, 16'hFFFF);
        waitBits(base + 7 * OSF + 1, "sat_f7");
        checkOutput("sat_count_hold", underrun_count, 16'hFFFF);
        checkOutput("sat_pulses", underrun_seen - ur0, 5);

        // Backpressure: one accept per frame, in order, ready low after each accept
        applyStimulus(1'b0, 1'b0, 16'h0000);
        advance(2);
        checkOutput("disable_count_kept", underrun_count, 16'hFFFF);
        checkOutput("disable_ready", pcm_ready, 1);
        na  = accept_cyc.size();
        ur0 = underrun_seen;
        val = 16'h0100;
        applyStimulus(1'b1, 1'b1, val);
        for (int c = 0; c < 5 * FRAME_CLKS + 20; c++) begin
            acc = pcm_ready;
            advance(1);
            if (acc) begin
                checkOutput($sformatf("ready_drop_after_0x%0h", val), pcm_ready, 0);
                val++;
                applyStimulus(1'b1, 1'b1, val);
            end
        end
        checkOutput("accept_count", accept_cyc.size() - na, 6);
        for (int k = 0; k < 6; k++) begin
            if (na + k < accept_val.size())
                checkOutput($sformatf("accept_order_%0d", k), accept_val[na + k], 16'h0100 + k);
        end
        if (na + 1 < accept_cyc.size())
            checkOutput("first_accept_gap", accept_cyc[na + 1] - accept_cyc[na],
                        FRAME_CLKS - CLK_DIV + HALF + 1);
        for (int k = 2; k < 6; k++) begin
            if (na + k < accept_cyc.size())
                checkOutput($sformatf("accept_gap_%0d", k), accept_cyc[na + k] - accept_cyc[na + k - 1],
                            FRAME_CLKS);
        end
        checkOutput("backpressure_underruns", underrun_seen - ur0, 0);

        // Enable drop at bit 31 (a '1' in the zero stream), then re-enable
        applyStimulus(1'b0, 1'b1, 16'h0000);
        advance(2);
        base = bit_idx;
        applyStimulus(1'b1, 1'b1, 16'h0000);
        waitBits(base + 32, "drop_wait");
        checkOutput("pre_drop_data", pdm_data, 1);
        checkOutput("pre_drop_ready", pcm_ready, 0);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        advance(1);
        checkOutput("drop_pdm_clk", pdm_clk, 0);
        checkOutput("drop_pdm_data", pdm_data, 0);
        checkOutput("drop_active", active, 0);
        checkOutput("drop_pcm_ready", pcm_ready, 1);
        advance(3);
        base = bit_idx;
        applyStimulus(1'b1, 1'b1, 16'h0000);
        waitBits(base + 41, "reenable");
        checkPattern(base, 41, "reenable_pattern");

        // Asynchronous reset between clock edges while pdm_clk and pdm_data are high
        #2 rst = 1'b1;
        #1;
        checkOutput("async_pdm_clk", pdm_clk, 0);
        checkOutput("async_pdm_data", pdm_data, 0);
        checkOutput("async_active", active, 0);
        checkOutput("async_pcm_ready", pcm_ready, 1);
        checkOutput("async_underrun_count", underrun_count, 0);
        base = bit_idx;
        #3 rst = 1'b0;
        waitBits(base + 13, "post_reset");
        checkPattern(base, 13, "post_reset_pattern");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
